// File: rtl/cmp_result_stage.sv
// Result stage behind the 16-bit comparator: one-hot decode, running signed max/min, event counters, 2-entry skid buffer.
// Define CMP_STAGE_CGATE_EN to clock the enabled state from a latch-based gated clock instead of an enable mux.
module cmp_result_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [1:0]         in_cmp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_lt,
  output logic               out_eq,
  output logic               out_gt,
  output logic [DATA_W-1:0]  out_max,
  output logic [DATA_W-1:0]  out_min,
  output logic [DATA_W-1:0]  run_max,
  output logic [DATA_W-1:0]  run_min,
  output logic               run_seen,
  output logic [COUNT_W-1:0] cnt_lt,
  output logic [COUNT_W-1:0] cnt_eq,
  output logic [COUNT_W-1:0] cnt_gt,
  output logic               err
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              lt;
    logic              eq;
    logic              gt;
    logic [DATA_W-1:0] mx;
    logic [DATA_W-1:0] mn;
  } entry_t;

  logic   accept, pop, en;
  logic   sclk, upd;
  logic   illegal;
  entry_t dec;

  entry_t       head_q, head_d, tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         valid_q, full_q;

  logic [DATA_W-1:0]  run_max_q, run_max_d, run_min_q, run_min_d;
  logic               seen_q, seen_d, err_q, err_d;
  logic [COUNT_W-1:0] lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign en     = accept | pop | clr;

`ifdef CMP_STAGE_CGATE_EN
  // Enable is captured while clk is low so the gated clock never glitches.
  logic en_lat;
  always_latch begin
    if (!clk) en_lat = en;
  end
  assign sclk = clk & en_lat;
  assign upd  = 1'b1;
`else
  assign sclk = clk;
  assign upd  = en;
`endif

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + COUNT_W'(1);
  endfunction

  // Decode the comparator code; max/min are selected, never recomputed.
  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (in_cmp)
      2'b11:   dec.lt = 1'b1;
      2'b01:   dec.gt = 1'b1;
      2'b00:   dec.eq = 1'b1;
      default: begin
        dec.eq  = 1'b1;
        illegal = 1'b1;
      end
    endcase
    dec.mx = dec.gt ? in_a : in_b;
    dec.mn = dec.lt ? in_a : in_b;
  end

  // Skid buffer next state: head is entry 0, tail is entry 1.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({accept, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = dec;
        else               tail_d = dec;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = dec;
        end else begin
          head_d = tail_q;
          tail_d = dec;
        end
      end
      default: ;
    endcase
  end

  // Running extremes and counters; clr with an accept seeds from the new sample.
  always_comb begin
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    seen_d    = seen_q;
    err_d     = err_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    if (accept) begin
      if (!seen_q || clr) begin
        run_max_d = dec.mx;
        run_min_d = dec.mn;
        seen_d    = 1'b1;
        err_d     = illegal;
        lt_d      = COUNT_W'(dec.lt);
        eq_d      = COUNT_W'(dec.eq);
        gt_d      = COUNT_W'(dec.gt);
      end else begin
        if ($signed(dec.mx) > $signed(run_max_q)) run_max_d = dec.mx;
        if ($signed(dec.mn) < $signed(run_min_q)) run_min_d = dec.mn;
        err_d = err_q | illegal;
        if (dec.lt) lt_d = sat_inc(lt_q);
        if (dec.eq) eq_d = sat_inc(eq_q);
        if (dec.gt) gt_d = sat_inc(gt_q);
      end
    end else if (clr) begin
      run_max_d = '0;
      run_min_d = '0;
      seen_d    = 1'b0;
      err_d     = 1'b0;
      lt_d      = '0;
      eq_d      = '0;
      gt_d      = '0;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= 2'd0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      run_max_q <= '0;
      run_min_q <= '0;
      seen_q    <= 1'b0;
      err_q     <= 1'b0;
      lt_q      <= '0;
      eq_q      <= '0;
      gt_q      <= '0;
    end else if (upd) begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      valid_q   <= (occ_d != 2'd0);
      full_q    <= (occ_d == 2'd2);
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
    end
  end

  assign in_ready  = ~full_q;
  assign out_valid = valid_q;
  assign out_lt    = head_q.lt;
  assign out_eq    = head_q.eq;
  assign out_gt    = head_q.gt;
  assign out_max   = head_q.mx;
  assign out_min   = head_q.mn;
  assign run_max   = run_max_q;
  assign run_min   = run_min_q;
  assign run_seen  = seen_q;
  assign cnt_lt    = lt_q;
  assign cnt_eq    = eq_q;
  assign cnt_gt    = gt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cmp_result_stage.sv
// Scoreboard bench for cmp_result_stage: expected head entries queued on accept, compared on pop,
// with a reference model of the running extremes, counters and error flag.
module tb_cmp_result_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_a, in_b;
  logic [1:0]    in_cmp;
  logic          out_lt, out_eq, out_gt, run_seen, err;
  logic [DW-1:0] out_max, out_min, run_max, run_min;
  logic [CW-1:0] cnt_lt, cnt_eq, cnt_gt;

  cmp_result_stage #(.DATA_W(DW), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cmp(in_cmp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lt(out_lt), .out_eq(out_eq), .out_gt(out_gt),
    .out_max(out_max), .out_min(out_min),
    .run_max(run_max), .run_min(run_min), .run_seen(run_seen),
    .cnt_lt(cnt_lt), .cnt_eq(cnt_eq), .cnt_gt(cnt_gt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          lt;
    logic          eq;
    logic          gt;
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic last_acc;

  logic [DW-1:0] m_max, m_min;
  logic          m_seen, m_err;
  logic [CW-1:0] m_lt, m_eq, m_gt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_max = '0; m_min = '0; m_seen = 1'b0; m_err = 1'b0;
    m_lt = '0; m_eq = '0; m_gt = '0;
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + CW'(1);
  endfunction

  // One clock: handshake decisions at the falling edge, state checks just after the rising edge.
  task automatic cycle();
    exp_t e;
    logic acc, pp;
    @(negedge clk);
    check("out_valid", out_valid, q.size() != 0);
    check("in_ready", in_ready, q.size() < 2);
    acc = in_valid && (q.size() < 2);
    pp  = out_ready && (q.size() != 0);
    if (pp) begin
      e = q.pop_front();
      check("head_lt", out_lt, e.lt);
      check("head_eq", out_eq, e.eq);
      check("head_gt", out_gt, e.gt);
      check("head_max", out_max, e.mx);
      check("head_min", out_min, e.mn);
    end
    if (acc) begin
      e.lt = (in_cmp == 2'b11);
      e.gt = (in_cmp == 2'b01);
      e.eq = ~in_cmp[0];
      e.mx = e.gt ? in_a : in_b;
      e.mn = e.lt ? in_a : in_b;
      q.push_back(e);
      if (!m_seen || clr) begin
        m_max = e.mx; m_min = e.mn; m_seen = 1'b1;
        m_err = (in_cmp == 2'b10);
        m_lt = CW'(e.lt); m_eq = CW'(e.eq); m_gt = CW'(e.gt);
      end else begin
        if ($signed(e.mx) > $signed(m_max)) m_max = e.mx;
        if ($signed(e.mn) < $signed(m_min)) m_min = e.mn;
        m_err = m_err | (in_cmp == 2'b10);
        if (e.lt) m_lt = sat(m_lt);
        if (e.eq) m_eq = sat(m_eq);
        if (e.gt) m_gt = sat(m_gt);
      end
    end else if (clr) begin
      model_reset();
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    check("run_max", run_max, m_max);
    check("run_min", run_min, m_min);
    check("run_seen", run_seen, m_seen);
    check("cnt_lt", cnt_lt, m_lt);
    check("cnt_eq", cnt_eq, m_eq);
    check("cnt_gt", cnt_gt, m_gt);
    check("err", err, m_err);
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] c);
    in_a = a; in_b = b; in_cmp = c; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ra, rb;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cmp = 2'b00; last_acc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_out_max", out_max, 0);
    check("rst_out_min", out_min, 0);
    check("rst_cnt_gt", cnt_gt, 0);

    // Single GT sample, 1-cycle latency.
    out_ready = 1'b1;
    send(16'd5, 16'hFFFD, 2'b01);
    check("s1_valid", out_valid, 1);
    check("s1_gt", out_gt, 1);
    check("s1_max", out_max, 16'd5);
    check("s1_min", out_min, 16'hFFFD);
    check("s1_cnt_gt", cnt_gt, 1);
    drain();

    // Backpressure: two accepts fill the buffer, third is held.
    out_ready = 1'b0;
    send(16'd1, 16'd2, 2'b11);
    send(16'd3, 16'd3, 2'b00);
    in_a = 16'd9; in_b = 16'hFFF7; in_cmp = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("held", last_acc, 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (last_acc) break;
    end
    check("release_acc", last_acc, 1);
    in_valid = 1'b0;
    drain();

    // Extremes at the signed limits.
    clr = 1'b1; cycle(); clr = 1'b0;
    send(16'h8000, 16'h7FFF, 2'b11);
    send(16'd7, 16'd7, 2'b00);
    check("ext_min", run_min, 16'h8000);
    check("ext_max", run_max, 16'h7FFF);
    check("ext_lt", cnt_lt, 1);
    check("ext_eq", cnt_eq, 1);
    drain();

    // Counter saturation, clear, and clear together with an accept.
    for (int i = 0; i < 300; i++) send(16'd20, 16'd10, 2'b01);
    check("sat_gt", cnt_gt, 255);
    clr = 1'b1; cycle(); clr = 1'b0;
    check("clr_gt", cnt_gt, 0);
    send(16'd4, 16'd2, 2'b01);
    clr = 1'b1; send(16'd8, 16'd1, 2'b01); clr = 1'b0;
    check("clr_acc_gt", cnt_gt, 1);
    check("clr_acc_max", run_max, 16'd8);
    drain();

    // Illegal comparator code decodes as EQ and sets a sticky error.
    send(16'd2, 16'd6, 2'b10);
    check("illegal_err", err, 1);
    send(16'd1, 16'd0, 2'b01);
    send(16'd0, 16'd1, 2'b11);
    check("err_sticky", err, 1);
    clr = 1'b1; cycle(); clr = 1'b0;
    check("err_clr", err, 0);
    drain();

    // Asynchronous reset with two buffered entries.
    out_ready = 1'b0;
    send(16'd11, 16'd12, 2'b11);
    send(16'd13, 16'd12, 2'b01);
    check("full_before_rst", in_ready, 0);
    #2;
    do_reset();
    check("rst_seen", run_seen, 0);

    // Random traffic with random backpressure and occasional clears.
    for (int i = 0; i < 250; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        ra = DW'($urandom); rb = DW'($urandom);
        if ($urandom_range(0, 3) == 0) rb = ra;
        in_a = ra; in_b = rb;
        in_cmp = ($signed(ra) < $signed(rb)) ? 2'b11 :
                 ($signed(ra) > $signed(rb)) ? 2'b01 : 2'b00;
        if ($urandom_range(0, 40) == 0) in_cmp = 2'b10;
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 31) == 0);
      cycle();
      if (last_acc) in_valid = 1'b0;
    end
    clr = 1'b0; in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
